// File: rtl/cu_seq.sv
// Round-robin command sequencer for the 4-channel control-unit decode bus.
// Latches one requesting channel and steps the phase code through SEL, XFER, REL.
module cu_seq #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       grant,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       o,
    output logic       busy,
    output logic [3:0] done,
    output logic       err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    ch, ch_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    done_nxt;
    logic          err_nxt;
    logic [1:0]    ab_nxt;
    logic [4:0]    code_nxt;
    logic          busy_nxt;

    // First set request bit at or above p, wrapping mod 4; lowest offset wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    // Phase code {c,d,e,f,o}; d=1 keeps every decoder output inactive.
    function automatic logic [4:0] phase_code(input state_t s);
        case (s)
            SEL:     phase_code = 5'b00010;
            XFER:    phase_code = 5'b00111;
            default: phase_code = 5'b01000;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        done_nxt  = 4'b0000;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    ch_nxt    = rr_pick(req, ptr);
                    state_nxt = SEL;
                end
            end
            SEL: begin
                cnt_nxt   = '0;
                state_nxt = XFER;
            end
            XFER: begin
                if (grant) begin
                    done_nxt  = 4'b0001 << ch;
                    state_nxt = REL;
                end else if (cnt == LAST_WAIT) begin
                    err_nxt   = 1'b1;
                    state_nxt = REL;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            REL: begin
                ptr_nxt   = ch + 2'd1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        ab_nxt   = (state_nxt == IDLE) ? 2'b00 : ch_nxt;
        code_nxt = phase_code(state_nxt);
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ch    <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a    <= 1'b0;
            b    <= 1'b0;
            c    <= 1'b0;
            d    <= 1'b1;
            e    <= 1'b0;
            f    <= 1'b0;
            o    <= 1'b0;
            busy <= 1'b0;
            done <= 4'b0000;
            err  <= 1'b0;
        end else begin
            {a, b}          <= ab_nxt;
            {c, d, e, f, o} <= code_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            err             <= err_nxt;
        end
    end

endmodule
